j1_io_uart: RTL and testbench

- Memory-mapped I/O responder on the j1 core's I/O port: decodes io_ptr, accepts io_we writes of io_out, and returns io_in for io_re reads.
- Hosts one 8N1 UART (TX and RX) plus status and baud-divisor registers.
- Sits beside the j1 core at the top level; it is the slave end of the core's I/O interface.

---
 rtl/j1_io_pkg.sv | 17 +
 rtl/j1_uart_rx.sv | 97 +++++++++
 rtl/j1_io_uart.sv | 186 ++++++++++++++++++
 tb/tb_j1_io_uart.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
// Shared constants and FSM state types for the j1 I/O-mapped UART.
package j1_io_pkg;

  localparam logic [15:0] IO_UART_DATA   = 16'h4000;
  localparam logic [15:0] IO_UART_STATUS = 16'h4001;
  localparam logic [15:0] IO_UART_DIV    = 16'h4002;

  localparam int ST_TX_READY   = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_TX_DROP    = 3;
  localparam int ST_LOOPBACK   = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/j1_uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM and shift register.
module j1_uart_rx
  import j1_io_pkg::*;
#(
  parameter int DIV_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rxd_i,
  input  logic [DIV_BITS-1:0] div_i,
  output logic [7:0]          byte_o,
  output logic                byte_strobe_o,
  output logic                framing_err_o
);

  logic                sync1_q, sync2_q, prev_q;
  rx_state_e           state_q, state_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [DIV_BITS-1:0] half;

  assign half   = div_i >> 1;
  assign byte_o = shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // The START wait lands the first sample mid-bit; later samples step a full period.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    byte_strobe_o = 1'b0;
    framing_err_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = (half == '0) ? '0 : half - DIV_BITS'(1);
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = div_i - DIV_BITS'(1);
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = div_i - DIV_BITS'(1);
          if (bit_q == 3'd7) state_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (sync2_q) byte_strobe_o = 1'b1;
          else framing_err_o = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/j1_io_uart.sv
// j1 I/O-port slave hosting an 8N1 UART with status and baud-divisor registers.
// Optional J1_IO_UART_LOOPBACK_EN adds a STATUS bit8 internal TX->RX loopback.
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = 217,
  parameter int DIV_BITS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [WIDTH-1:0] io_ptr,
  input  logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_in,
  output logic             uart_txd,
  input  logic             uart_rxd
);

  logic sel_data, sel_status, sel_div;
  logic wr_data, wr_div, rd_data, rd_status;

  assign sel_data   = (io_ptr == WIDTH'(IO_UART_DATA));
  assign sel_status = (io_ptr == WIDTH'(IO_UART_STATUS));
  assign sel_div    = (io_ptr == WIDTH'(IO_UART_DIV));
  assign wr_data    = io_we & sel_data;
  assign wr_div     = io_we & sel_div;
  assign rd_data    = io_re & sel_data;
  assign rd_status  = io_re & sel_status;

  tx_state_e           tx_state_q, tx_state_d;
  logic [DIV_BITS-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [7:0]          rx_byte_q, rx_byte_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_overrun_q, rx_overrun_d;
  logic                tx_drop_q, tx_drop_d;
  logic                tx_ready, tx_line, rx_in;
  logic [7:0]          rx_new_byte;
  logic                rx_strobe, rx_framing_err_unused;
  logic [DIV_BITS-1:0] div_wr;

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign div_wr   = DIV_BITS'(io_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      div_q        <= DIV_BITS'(DIV_RESET);
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      div_q        <= div_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  // Flag updates list clears before sets so a coincident set wins.
  always_comb begin
    div_d        = div_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    tx_drop_d    = tx_drop_q;
    if (wr_div) div_d = (div_wr == '0) ? DIV_BITS'(1) : div_wr;
    if (rd_status) begin
      rx_overrun_d = 1'b0;
      tx_drop_d    = 1'b0;
    end
    if (wr_data && !tx_ready) tx_drop_d = 1'b1;
    if (rd_data) rx_valid_d = 1'b0;
    if (rx_strobe) begin
      if (rx_valid_q && !rd_data) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_new_byte;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line    = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (wr_data) begin
          tx_state_d = TX_START;
          tx_cnt_d   = div_q - DIV_BITS'(1);
          tx_shift_d = io_out[7:0];
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = div_q - DIV_BITS'(1);
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_BITS'(1);
        end
      end
      TX_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_q - DIV_BITS'(1);
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_BITS'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
        else tx_cnt_d = tx_cnt_q - DIV_BITS'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

`ifdef J1_IO_UART_LOOPBACK_EN
  logic loop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loop_q <= 1'b0;
    else if (io_we && sel_status) loop_q <= io_out[ST_LOOPBACK];
  end

  assign rx_in    = loop_q ? tx_line : uart_rxd;
  assign uart_txd = loop_q ? 1'b1 : tx_line;
`else
  assign rx_in    = uart_rxd;
  assign uart_txd = tx_line;
`endif

  j1_uart_rx #(.DIV_BITS(DIV_BITS)) u_rx (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rxd_i         (rx_in),
    .div_i         (div_q),
    .byte_o        (rx_new_byte),
    .byte_strobe_o (rx_strobe),
    .framing_err_o (rx_framing_err_unused)
  );

  // Read data must be valid within the strobe cycle, so it is purely combinational.
  always_comb begin
    io_in = '0;
    if (sel_data) begin
      io_in[7:0] = rx_byte_q;
    end else if (sel_status) begin
      io_in[ST_TX_READY]   = tx_ready;
      io_in[ST_RX_VALID]   = rx_valid_q;
      io_in[ST_RX_OVERRUN] = rx_overrun_q;
      io_in[ST_TX_DROP]    = tx_drop_q;
`ifdef J1_IO_UART_LOOPBACK_EN
      io_in[ST_LOOPBACK]   = loop_q;
`endif
    end else if (sel_div) begin
      io_in = WIDTH'(div_q);
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Directed bench for j1_io_uart: register table, TX/RX framing and flag corner cases.
module tb_j1_io_uart;

  localparam logic [15:0] A_DATA   = 16'h4000;
  localparam logic [15:0] A_STATUS = 16'h4001;
  localparam logic [15:0] A_DIV    = 16'h4002;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_we = 1'b0;
  logic        io_re = 1'b0;
  logic [15:0] io_ptr = '0;
  logic [15:0] io_out = '0;
  logic [15:0] io_in;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    bit          isWrite;
    logic [15:0] ptr;
    logic [15:0] data;
    logic [15:0] expRead;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  j1_io_uart #(.WIDTH(16), .DIV_RESET(217), .DIV_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_we    (io_we),
    .io_re    (io_re),
    .io_ptr   (io_ptr),
    .io_out   (io_out),
    .io_in    (io_in),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic ioWrite(input logic [15:0] addr, input logic [15:0] data);
    io_we = 1'b1; io_ptr = addr; io_out = data;
    @(posedge clk); #1;
    io_we = 1'b0;
  endtask

  task automatic ioRead(input logic [15:0] addr, output logic [15:0] data);
    io_re = 1'b1; io_ptr = addr;
    #1 data = io_in;
    @(posedge clk); #1;
    io_re = 1'b0;
  endtask

  task automatic readCheck(input logic [15:0] addr, input logic [15:0] expected, input string name);
    logic [15:0] v;
    ioRead(addr, v);
    checkOutput(name, v, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addVec(input bit w, input logic [15:0] p, input logic [15:0] d,
                        input logic [15:0] e, input string n);
    vec_t v;
    v.isWrite = w; v.ptr = p; v.data = d; v.expRead = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isWrite) ioWrite(v.ptr, v.data);
    else readCheck(v.ptr, v.expRead, v.name);
  endtask

  // Drives one serial frame; optionally issues a DATA read whose edge coincides with the stop sample.
  task automatic sendFrame(input logic [7:0] b, input bit stopVal, input int div,
                           input bit readAtEnd, output logic [15:0] readVal);
    logic [9:0] bits;
    bits = {stopVal, b, 1'b0};
    readVal = '0;
    for (int c = 0; c < 10 * div; c++) begin
      uart_rxd = bits[c / div];
      if (readAtEnd && c == 10 * div - 2) begin
        io_re = 1'b1; io_ptr = A_DATA;
        #1 readVal = io_in;
      end
      @(posedge clk); #1;
      io_re = 1'b0;
    end
    uart_rxd = 1'b1;
  endtask

  initial begin
    logic [9:0]  txBits;
    logic [15:0] rv;
    bit          allHigh;

    addVec(1'b0, A_STATUS, 16'h0000, 16'h0001, "reset_status");
    addVec(1'b0, A_DIV,    16'h0000, 16'h00D9, "reset_div");
    addVec(1'b0, A_DATA,   16'h0000, 16'h0000, "reset_data");
    addVec(1'b0, 16'h4003, 16'h0000, 16'h0000, "unmapped_read");
    addVec(1'b0, 16'hC001, 16'h0000, 16'h0000, "alias_read");
    addVec(1'b1, A_DIV,    16'h0000, 16'h0000, "");
    addVec(1'b0, A_DIV,    16'h0000, 16'h0001, "div_zero_as_one");
    addVec(1'b1, A_DIV,    16'hABCD, 16'h0000, "");
    addVec(1'b0, A_DIV,    16'h0000, 16'hABCD, "div_rw");
    addVec(1'b1, 16'h4003, 16'hFFFF, 16'h0000, "");
    addVec(1'b0, 16'h4003, 16'h0000, 16'h0000, "unmapped_write");
    addVec(1'b1, A_STATUS, 16'h000F, 16'h0000, "");
    addVec(1'b0, A_STATUS, 16'h0000, 16'h0001, "status_ro");
    addVec(1'b1, A_DIV,    16'h0004, 16'h0000, "");
    addVec(1'b0, A_DIV,    16'h0000, 16'h0004, "div_four");

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    allHigh = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (uart_txd !== 1'b1) allHigh = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("txd_idle_1000", {15'b0, allHigh}, 16'h0001);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // TX 0xA5 at DIV=4 with a dropped write and STATUS reads mid-frame
    $display("[TB] TX frame 0xA5");
    txBits = {1'b1, 8'hA5, 1'b0};
    ioWrite(A_DATA, 16'h00A5);
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin io_we = 1'b1; io_ptr = A_DATA; io_out = 16'h0033; end
      if (i == 10 || i == 12) begin io_re = 1'b1; io_ptr = A_STATUS; end
      #1;
      if (i % 4 == 2) checkOutput($sformatf("tx_bit%0d", i / 4), {15'b0, uart_txd}, {15'b0, txBits[i / 4]});
      if (i == 10) checkOutput("status_drop", io_in, 16'h0008);
      if (i == 12) checkOutput("status_drop_clr", io_in, 16'h0000);
      @(posedge clk); #1;
      io_we = 1'b0; io_re = 1'b0;
    end
    readCheck(A_STATUS, 16'h0001, "tx_ready_after");

    $display("[TB] RX tests at DIV=8");
    ioWrite(A_DIV, 16'h0008);
    sendFrame(8'h3C, 1'b1, 8, 1'b0, rv);
    waitCycles(2);
    readCheck(A_STATUS, 16'h0003, "rx_valid_set");
    readCheck(A_DATA, 16'h003C, "rx_byte_3c");
    readCheck(A_STATUS, 16'h0001, "rx_valid_clr");

    sendFrame(8'h11, 1'b1, 8, 1'b0, rv);
    sendFrame(8'h22, 1'b1, 8, 1'b0, rv);
    waitCycles(2);
    readCheck(A_STATUS, 16'h0007, "rx_overrun_set");
    readCheck(A_DATA, 16'h0011, "rx_old_kept");
    readCheck(A_STATUS, 16'h0001, "rx_overrun_clr");

    uart_rxd = 1'b0;
    waitCycles(2);
    uart_rxd = 1'b1;
    waitCycles(20);
    readCheck(A_STATUS, 16'h0001, "rx_glitch");

    sendFrame(8'h5A, 1'b0, 8, 1'b0, rv);
    waitCycles(10);
    readCheck(A_STATUS, 16'h0001, "rx_framing");

    sendFrame(8'h55, 1'b1, 8, 1'b0, rv);
    sendFrame(8'hA3, 1'b1, 8, 1'b1, rv);
    checkOutput("rx_simul_old", rv, 16'h0055);
    waitCycles(2);
    readCheck(A_STATUS, 16'h0003, "rx_simul_status");
    readCheck(A_DATA, 16'h00A3, "rx_simul_new");

`ifdef J1_IO_UART_LOOPBACK_EN
    $display("[TB] loopback");
    ioWrite(A_STATUS, 16'h0100);
    readCheck(A_STATUS, 16'h0101, "loop_status");
    ioWrite(A_DATA, 16'h007E);
    allHigh = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (uart_txd !== 1'b1) allHigh = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("loop_txd_high", {15'b0, allHigh}, 16'h0001);
    readCheck(A_STATUS, 16'h0103, "loop_rx_valid");
    readCheck(A_DATA, 16'h007E, "loop_byte");
    ioWrite(A_STATUS, 16'h0000);
`endif

    ioWrite(A_DATA, 16'h0000);
    #1 checkOutput("midframe_start", {15'b0, uart_txd}, 16'h0000);
    rst_n = 1'b0;
    #1 checkOutput("async_reset_txd", {15'b0, uart_txd}, 16'h0001);
    @(posedge clk); #1 rst_n = 1'b1;
    readCheck(A_DIV, 16'h00D9, "div_after_reset");
    readCheck(A_STATUS, 16'h0001, "status_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
